// File: rtl/pcm_mc.sv
// Multi-channel PCM playback engine: byte FIFO, fractional-rate frame pacing,
// per-channel log volume and a sticky underrun flag.
module pcm_mc #(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4096,
    parameter int RATE_W     = 8,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                next_sample,
    input  logic [RATE_W-1:0]   sample_rate,
    input  logic [CH_W-1:0]     ch_active,
    input  logic                mode_16bit,
    input  logic                hold_on_underrun,
    input  logic [4*NUM_CH-1:0] volume,
    input  logic [LVL_W-1:0]    ae_threshold,
    input  logic                fifo_reset,
    input  logic [7:0]          fifo_wrdata,
    input  logic                fifo_write,
    output logic                fifo_full,
    output logic                fifo_almost_empty,
    output logic                fifo_empty,
    output logic [LVL_W-1:0]    fifo_level,
    output logic                underrun,
    input  logic                underrun_clr,
    output logic                frame_strobe,
    output logic [16*NUM_CH-1:0] audio_out
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int FB_W = $clog2(2 * NUM_CH) + 1;
    localparam logic [RATE_W-1:0] RATE_MAX = {1'b1, {(RATE_W-1){1'b0}}};
    localparam logic [CH_W-1:0]   CH_MAX   = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_COMMIT} state_t;
    state_t state, state_nx;

    // rate accumulator
    logic [RATE_W-1:0] rate_c, acc, acc_sum;
    logic              new_sample;

    assign rate_c  = (sample_rate > RATE_MAX) ? RATE_MAX : sample_rate;
    assign acc_sum = acc + rate_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            new_sample <= 1'b0;
        end else begin
            new_sample <= next_sample && (acc_sum[RATE_W-1] != acc[RATE_W-1]);
            if (next_sample)
                acc <= acc_sum;
        end
    end

    // byte FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    rd_data;
    logic          rd_en, wr_ok, rd_ok;

    assign fifo_full         = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign fifo_empty        = (fifo_level == '0);
    assign fifo_almost_empty = (fifo_level < ae_threshold);
    assign wr_ok = fifo_write && !fifo_full && !fifo_reset;
    assign rd_ok = rd_en && !fifo_empty && !fifo_reset;

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= fifo_wrdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            rd_data    <= '0;
        end else if (fifo_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // frame control
    logic [CH_W-1:0] ch_c, lat_ch;
    logic [FB_W-1:0] frame_b, lat_b, idx, cap_ch;
    logic            lat_16;
    logic            start, under, capture, commit;

    assign ch_c    = (ch_active > CH_MAX) ? CH_MAX : ch_active;
    assign frame_b = (FB_W'(ch_c) + FB_W'(1)) << mode_16bit;
    assign cap_ch  = lat_16 ? (idx >> 1) : idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        rd_en        = 1'b0;
        start        = 1'b0;
        under        = 1'b0;
        capture      = 1'b0;
        commit       = 1'b0;
        frame_strobe = 1'b0;
        case (state)
            S_IDLE: begin
                if (new_sample && !fifo_reset) begin
                    if (fifo_level >= LVL_W'(frame_b)) begin
                        start    = 1'b1;
                        rd_en    = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        under = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (fifo_reset) begin
                    state_nx = S_IDLE;
                end else begin
                    capture = 1'b1;
                    if ((idx + FB_W'(1)) < lat_b)
                        rd_en = 1'b1;
                    else
                        state_nx = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_nx = S_IDLE;
                if (!fifo_reset) begin
                    commit       = 1'b1;
                    frame_strobe = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // staging and output registers
    logic [15:0] stg     [NUM_CH];
    logic [15:0] out_reg [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_ch <= '0;
            lat_16 <= 1'b0;
            lat_b  <= '0;
            idx    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                stg[c]     <= '0;
                out_reg[c] <= '0;
            end
        end else begin
            if (start) begin
                lat_ch <= ch_c;
                lat_16 <= mode_16bit;
                lat_b  <= frame_b;
                idx    <= '0;
                for (int c = 0; c < NUM_CH; c++)
                    stg[c] <= '0;
            end
            if (fifo_reset && state != S_IDLE) begin
                for (int c = 0; c < NUM_CH; c++)
                    stg[c] <= '0;
            end
            if (capture) begin
                idx <= idx + FB_W'(1);
                for (int c = 0; c < NUM_CH; c++) begin
                    if (cap_ch == FB_W'(c)) begin
                        if (!lat_16)
                            stg[c] <= {rd_data, 8'h00};
                        else if (idx[0])
                            stg[c][15:8] <= rd_data;
                        else
                            stg[c][7:0] <= rd_data;
                    end
                end
            end
            if (under && !hold_on_underrun) begin
                for (int c = 0; c < NUM_CH; c++)
                    out_reg[c] <= '0;
            end
            // a mono frame is broadcast; unused channels of a wider frame are silenced
            if (commit) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (lat_ch == '0)
                        out_reg[c] <= stg[0];
                    else if (c <= int'(lat_ch))
                        out_reg[c] <= stg[c];
                    else
                        out_reg[c] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            underrun <= 1'b0;
        else if (under)
            underrun <= 1'b1;
        else if (underrun_clr)
            underrun <= 1'b0;
    end

    // log volume: 7-bit gain where 64 is unity
    function automatic logic [6:0] vol_gain(input logic [3:0] v);
        case (v)
            4'd0:    vol_gain = 7'd0;
            4'd1:    vol_gain = 7'd1;
            4'd2:    vol_gain = 7'd2;
            4'd3:    vol_gain = 7'd3;
            4'd4:    vol_gain = 7'd4;
            4'd5:    vol_gain = 7'd5;
            4'd6:    vol_gain = 7'd6;
            4'd7:    vol_gain = 7'd8;
            4'd8:    vol_gain = 7'd11;
            4'd9:    vol_gain = 7'd14;
            4'd10:   vol_gain = 7'd18;
            4'd11:   vol_gain = 7'd23;
            4'd12:   vol_gain = 7'd30;
            4'd13:   vol_gain = 7'd38;
            4'd14:   vol_gain = 7'd49;
            default: vol_gain = 7'd64;
        endcase
    endfunction

    logic signed [21:0] prod    [NUM_CH];
    logic        [15:0] audio_q [NUM_CH];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++)
            prod[c] = 22'($signed(out_reg[c])) * 22'($signed({1'b0, vol_gain(volume[4*c +: 4])}));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++)
                audio_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++)
                audio_q[c] <= 16'(prod[c] >>> 6);
        end
    end

    always_comb begin
        audio_out = '0;
        for (int c = 0; c < NUM_CH; c++)
            audio_out[16*c +: 16] = audio_q[c];
    end

endmodule

// File: tb/tb_pcm_mc.sv
// Bench for pcm_mc: directed and randomized playback against a byte-queue
// reference model of frames, pacing, volume and underrun behaviour.
module tb_pcm_mc;

  localparam int NCH = 4;
  localparam int DEPTH = 4096;

  logic        clk;
  logic        rst_n;
  logic        next_sample;
  logic [7:0]  sample_rate;
  logic [1:0]  ch_active;
  logic        mode_16bit;
  logic        hold_on_underrun;
  logic [15:0] volume;
  logic [12:0] ae_threshold;
  logic        fifo_reset;
  logic [7:0]  fifo_wrdata;
  logic        fifo_write;
  logic        fifo_full;
  logic        fifo_almost_empty;
  logic        fifo_empty;
  logic [12:0] fifo_level;
  logic        underrun;
  logic        underrun_clr;
  logic        frame_strobe;
  logic [63:0] audio_out;

  pcm_mc #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .RATE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .next_sample(next_sample), .sample_rate(sample_rate),
    .ch_active(ch_active), .mode_16bit(mode_16bit), .hold_on_underrun(hold_on_underrun),
    .volume(volume), .ae_threshold(ae_threshold), .fifo_reset(fifo_reset),
    .fifo_wrdata(fifo_wrdata), .fifo_write(fifo_write), .fifo_full(fifo_full),
    .fifo_almost_empty(fifo_almost_empty), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
    .underrun(underrun), .underrun_clr(underrun_clr), .frame_strobe(frame_strobe),
    .audio_out(audio_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0]  fifo_q[$];
  logic [63:0] exp_q[$];
  logic [15:0] out_m[NCH];
  bit          under_m;
  logic [7:0]  acc_m;
  int          gain_tab[16] = '{0, 1, 2, 3, 4, 5, 6, 8, 11, 14, 18, 23, 30, 38, 49, 64};
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic logic [15:0] scale(input logic [15:0] s, input logic [3:0] v);
    int p;
    p = int'($signed(s)) * gain_tab[v];
    return 16'(p >>> 6);
  endfunction

  function automatic logic [63:0] exp_audio();
    logic [63:0] e;
    e = '0;
    for (int c = 0; c < NCH; c++)
      e[16*c +: 16] = scale(out_m[c], volume[4*c +: 4]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b, input bit track);
    fifo_wrdata = b;
    fifo_write = 1'b1;
    tick();
    fifo_write = 1'b0;
    if (track) fifo_q.push_back(b);
  endtask

  task automatic flush();
    fifo_reset = 1'b1;
    tick();
    fifo_reset = 1'b0;
    fifo_q.delete();
  endtask

  // one base-rate tick; the model accumulator decides whether a sample slot opens
  task automatic pulse(output bit fired);
    logic [7:0] r, nxt;
    r = (sample_rate > 8'd128) ? 8'd128 : sample_rate;
    next_sample = 1'b1;
    tick();
    next_sample = 1'b0;
    nxt = acc_m + r;
    fired = nxt[7] ^ acc_m[7];
    acc_m = nxt;
  endtask

  task automatic play(input string tag, input bit wr_during);
    int b, lat;
    bit fired, started;
    logic [7:0] lo, hi, d;
    logic [15:0] samp[NCH];
    b = (int'(ch_active) + 1) * (mode_16bit ? 2 : 1);
    pulse(fired);
    started = fired && (fifo_q.size() >= b);
    if (started) begin
      for (int c = 0; c < NCH; c++) samp[c] = '0;
      for (int c = 0; c <= int'(ch_active); c++) begin
        if (mode_16bit) begin
          lo = fifo_q.pop_front();
          hi = fifo_q.pop_front();
          samp[c] = {hi, lo};
        end else begin
          hi = fifo_q.pop_front();
          samp[c] = {hi, 8'h00};
        end
      end
      for (int c = 0; c < NCH; c++)
        out_m[c] = (ch_active == 2'd0) ? samp[0] : ((c <= int'(ch_active)) ? samp[c] : 16'h0);
    end else if (fired) begin
      under_m = 1'b1;
      if (!hold_on_underrun)
        for (int c = 0; c < NCH; c++) out_m[c] = '0;
    end
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      if (wr_during && ($urandom_range(0, 1) == 1) && fifo_q.size() < 200) begin
        d = 8'($urandom);
        fifo_wrdata = d;
        fifo_write = 1'b1;
        fifo_q.push_back(d);
      end
      tick();
      fifo_write = 1'b0;
      if (frame_strobe) begin
        lat = k;
        break;
      end
    end
    // new_sample follows the tick by one cycle, then B+1 cycles to the strobe
    check({tag, "_latency"}, 64'(longint'(lat)), started ? 64'(longint'(b + 1)) : 64'(longint'(-1)));
    tick();
    check({tag, "_strobe_width"}, 64'(frame_strobe), 64'(0));
    exp_q.push_back(exp_audio());
    tick();
    check({tag, "_audio"}, audio_out, exp_q.pop_front());
    check({tag, "_level"}, 64'(fifo_level), 64'(fifo_q.size()));
    check({tag, "_underrun"}, 64'(underrun), 64'(under_m));
  endtask

  initial begin
    bit fired;
    bit fires[$];
    int b, n, strobes;
    logic [7:0] r;

    rst_n = 1'b0;
    next_sample = 1'b0;
    sample_rate = 8'd128;
    ch_active = 2'd0;
    mode_16bit = 1'b0;
    hold_on_underrun = 1'b0;
    volume = 16'hFFFF;
    ae_threshold = 13'd4;
    fifo_reset = 1'b0;
    fifo_wrdata = 8'h00;
    fifo_write = 1'b0;
    underrun_clr = 1'b0;
    acc_m = 8'h00;
    under_m = 1'b0;
    for (int c = 0; c < NCH; c++) out_m[c] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset state
    check("rst_empty", 64'(fifo_empty), 64'(1));
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_full", 64'(fifo_full), 64'(0));
    check("rst_almost_empty", 64'(fifo_almost_empty), 64'(1));
    check("rst_underrun", 64'(underrun), 64'(0));
    check("rst_strobe", 64'(frame_strobe), 64'(0));
    check("rst_audio", audio_out, 64'(0));

    // stereo 16-bit frame 11 22 33 44
    ch_active = 2'd1;
    mode_16bit = 1'b1;
    write_byte(8'h11, 1'b1);
    write_byte(8'h22, 1'b1);
    write_byte(8'h33, 1'b1);
    write_byte(8'h44, 1'b1);
    play("stereo16", 1'b0);
    check("stereo16_value", audio_out, 64'h0000_0000_4433_2211);

    // 8-bit mono broadcast with per-channel volume
    ch_active = 2'd0;
    mode_16bit = 1'b0;
    volume = 16'hFF8F;
    write_byte(8'h80, 1'b1);
    play("mono8", 1'b0);
    check("mono8_value", audio_out, 64'h8000_8000_EA00_8000);
    volume = 16'hFFFF;
    tick();
    check("volume_change", audio_out, exp_audio());

    // pacing: tick every cycle, empty FIFO, underrun mirrors each new_sample
    hold_on_underrun = 1'b1;
    n = 18;
    underrun_clr = 1'b1;
    for (int i = 0; i <= n + 1; i++) begin
      if (i >= 2) check($sformatf("rate_slot%0d", i - 2), 64'(underrun), 64'(fires[i - 2]));
      if (i < n) begin
        sample_rate = (i < 4) ? 8'd64 : (i < 8) ? 8'd255 : 8'($urandom_range(0, 255));
        next_sample = 1'b1;
        r = (sample_rate > 8'd128) ? 8'd128 : sample_rate;
        fires.push_back(((acc_m + r) & 8'h80) != (acc_m & 8'h80));
        acc_m = acc_m + r;
      end else begin
        next_sample = 1'b0;
      end
      tick();
    end
    underrun_clr = 1'b0;
    check("rate_audio_held", audio_out, exp_audio());
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    under_m = 1'b0;
    check("underrun_clr", 64'(underrun), 64'(0));

    // underrun with a partial frame queued
    sample_rate = 8'd128;
    ch_active = 2'd1;
    mode_16bit = 1'b1;
    hold_on_underrun = 1'b0;
    write_byte(8'hA1, 1'b1);
    write_byte(8'hB2, 1'b1);
    write_byte(8'hC3, 1'b1);
    play("ur_hold0", 1'b0);
    check("ur_hold0_zero", audio_out, 64'(0));
    write_byte(8'hD4, 1'b1);
    play("stereo_b", 1'b0);
    hold_on_underrun = 1'b1;
    play("ur_hold1", 1'b0);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    under_m = 1'b0;
    check("underrun_clr2", 64'(underrun), 64'(0));

    // randomized frames, sometimes with concurrent writes
    for (int it = 0; it < 10; it++) begin
      ch_active = 2'($urandom_range(0, 3));
      mode_16bit = 1'($urandom_range(0, 1));
      hold_on_underrun = 1'($urandom_range(0, 1));
      volume = 16'($urandom);
      sample_rate = 8'($urandom_range(64, 255));
      b = (int'(ch_active) + 1) * (mode_16bit ? 2 : 1);
      n = b + $urandom_range(0, 2);
      for (int j = 0; j < n; j++) write_byte(8'($urandom), 1'b1);
      play($sformatf("rand%0d", it), 1'($urandom_range(0, 1)));
    end

    // fifo_reset during FETCH aborts the frame
    flush();
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    under_m = 1'b0;
    ch_active = 2'd3;
    mode_16bit = 1'b1;
    sample_rate = 8'd128;
    for (int j = 0; j < 8; j++) write_byte(8'($urandom), 1'b1);
    pulse(fired);
    tick();
    tick();
    fifo_reset = 1'b1;
    tick();
    fifo_reset = 1'b0;
    fifo_q.delete();
    strobes = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (frame_strobe) strobes++;
    end
    check("abort_no_strobe", 64'(strobes), 64'(0));
    check("abort_level", 64'(fifo_level), 64'(0));
    check("abort_audio_kept", audio_out, exp_audio());
    ch_active = 2'd0;
    mode_16bit = 1'b0;
    write_byte(8'h5A, 1'b1);
    play("after_abort", 1'b0);

    // fill past capacity
    flush();
    for (int j = 0; j < DEPTH; j++) write_byte(8'(j), 1'b0);
    check("full_flag", 64'(fifo_full), 64'(1));
    check("full_level", 64'(fifo_level), 64'(DEPTH));
    check("full_not_ae", 64'(fifo_almost_empty), 64'(0));
    write_byte(8'hEE, 1'b0);
    check("full_drop_level", 64'(fifo_level), 64'(DEPTH));
    flush();
    check("flush_empty", 64'(fifo_empty), 64'(1));
    write_byte(8'h01, 1'b1);
    write_byte(8'h02, 1'b1);
    write_byte(8'h03, 1'b1);
    check("ae_level3", 64'(fifo_almost_empty), 64'(1));
    write_byte(8'h04, 1'b1);
    check("ae_level4", 64'(fifo_almost_empty), 64'(0));
    flush();

    // asynchronous reset in the middle of a frame
    hold_on_underrun = 1'b0;
    play("ur_pre", 1'b0);
    ch_active = 2'd1;
    mode_16bit = 1'b1;
    for (int j = 0; j < 4; j++) write_byte(8'($urandom), 1'b1);
    pulse(fired);
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    check("arst_audio", audio_out, 64'(0));
    check("arst_level", 64'(fifo_level), 64'(0));
    check("arst_empty", 64'(fifo_empty), 64'(1));
    check("arst_underrun", 64'(underrun), 64'(0));
    check("arst_strobe", 64'(frame_strobe), 64'(0));
    tick();
    rst_n = 1'b1;
    fifo_q.delete();
    acc_m = 8'h00;
    under_m = 1'b0;
    for (int c = 0; c < NCH; c++) out_m[c] = '0;
    write_byte(8'h12, 1'b1);
    write_byte(8'h34, 1'b1);
    write_byte(8'h56, 1'b1);
    write_byte(8'h78, 1'b1);
    play("post_reset", 1'b0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
